pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Next-PC controller that drives the program counter register's load enable and data input in the pipelined OTTER core. Each cycle it arbitrates between sequential fetch, taken branch/jump redirects from execute, `mret` returns and external interrupts. It honours hazard-unit stalls and instruction-memory busy, and buffers a redirect that arrives while fetch cannot accept it. It also emits pipeline flush and trap-entry signals to the CSR unit.

## Interface
- RESET_VEC, 32'h0000_0000, first fetch address after reset
- PS_CLK  in  1  clock; all state updates on rising edge
- PS_RST  in  1  synchronous active-high reset
- PS_PC  in  32  current PC register value
- PS_STALL  in  1  hazard-unit stall; blocks sequential advance only
- PS_IMEM_BUSY  in  1  instruction memory cannot accept a new address this cycle
- PS_BR_TAKEN  in  1  branch/jump resolved taken in execute
- PS_BR_TARGET  in  32  branch/jump target
- PS_MRET  in  1  `mret` resolved in execute
- PS_MEPC  in  32  return address from CSR mepc
- PS_INTR  in  1  level interrupt request
- PS_INTR_EN  in  1  mstatus.MIE
- PS_MTVEC  in  32  trap vector
- PS_DEC_PC  in  32  PC of instruction in decode
- PS_DEC_VALID  in  1  decode holds a valid (non-bubble) instruction
- PS_PC_LD  out  1  load enable to PC register
- PS_PC_DIN  out  32  next PC value
- PS_FLUSH  out  1  flush IF/ID and ID/EX this cycle
- PS_TRAP_TAKEN  out  1  one-cycle pulse on interrupt entry
- PS_TRAP_EPC  out  32  value for mepc, valid when PS_TRAP_TAKEN=1

## Operation
- FSM states: BOOT, RUN, PEND. Registers: 32-bit pend_target and in_trap flag.
- PS_RST=1: next state BOOT, in_trap<=0, pend_target<=0. All outputs are 0 while PS_RST is high, except PS_PC_DIN=RESET_VEC.
- BOOT (first cycle after reset release):
  - PC_LD=1, PC_DIN=RESET_VEC, FLUSH=1.
  - All requests ignored.
  - Next state RUN. IMEM_BUSY is ignored in this state.
- RUN, event priority is MRET > interrupt > branch > sequential:
  - MRET: target=MEPC; in_trap<=0.
  - Interrupt accepted when INTR & INTR_EN & !in_trap & DEC_VALID & !MRET:
    - target=MTVEC; TRAP_TAKEN=1; in_trap<=1.
    - TRAP_EPC=BR_TARGET if BR_TAKEN in the same cycle, else DEC_PC.
  - Branch: target=BR_TARGET.
  - Any redirect event sets FLUSH=1 in that cycle:
    - If !IMEM_BUSY: PC_LD=1, PC_DIN=target, stay RUN.
    - If IMEM_BUSY: PC_LD=0, pend_target<=target, go PEND.
  - No event: PC_LD = !STALL & !IMEM_BUSY, PC_DIN = PS_PC+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
- PEND:
  - FLUSH=1 every cycle; PC_DIN=pend_target.
  - PC_LD=!IMEM_BUSY. When it is 1, go RUN.
  - BR_TAKEN, MRET and INTR are ignored; they originate from flushed or wrong-path work. An interrupt is re-evaluated in RUN.
  - STALL is ignored.
- STALL never blocks a redirect.
- in_trap blocks nested interrupts. Only an accepted MRET clears it.

## Timing
- Outputs are combinational from the state register and the current inputs. State, pend_target and in_trap are registered.
- Redirect with memory ready: PC holds the target one edge after the event cycle (0-cycle bubble in the controller).
- Redirect with memory busy: PC holds the target one edge after the first cycle with IMEM_BUSY=0.
- Reset release to first valid PC: one edge. PS_PC=RESET_VEC after the BOOT cycle edge.
- TRAP_TAKEN is high for exactly one cycle per interrupt, including when the redirect is deferred to PEND.
- Reset asserted in PEND discards pend_target. The next state is BOOT regardless of other inputs.

## Test plan
- Reset then free run, RESET_VEC=32'h100, no stalls -> BOOT loads 32'h100 with FLUSH=1; PC advances 32'h104, 32'h108 each cycle with PC_LD=1.
- STALL=1 for 2 cycles at PC=32'h200 -> PC_LD=0 for those 2 cycles, PC stays 32'h200, then 32'h204; repeat with BR_TAKEN to 32'h40 during STALL -> PC_LD=1, PC=32'h40, FLUSH=1.
- BR_TAKEN target 32'h80 while IMEM_BUSY=1 for 3 cycles, with a second BR_TAKEN to 32'h90 in cycle 2 -> PC_LD=0 and FLUSH=1 for 3 cycles, then PC=32'h80; 32'h90 is never loaded.
- INTR=1, INTR_EN=1, DEC_VALID=1, DEC_PC=32'h300, MTVEC=32'h1000 -> TRAP_TAKEN=1 for one cycle, TRAP_EPC=32'h300, PC=32'h1000. INTR held high afterwards -> no second trap until MRET with MEPC=32'h300 returns PC to 32'h300.
- INTR with BR_TAKEN to 32'h500 same cycle -> TRAP_EPC=32'h500, PC=MTVEC. INTR with MRET same cycle -> PC=MEPC, TRAP_TAKEN=0, interrupt taken next eligible cycle.
- PC=32'hFFFF_FFFC sequential -> PC=32'h0; reset asserted while in PEND -> next cycle BOOT, PC_DIN=RESET_VEC, pending target dropped.

Source files
------------

// File: rtl/pc_sequencer.sv
// Next-PC controller for the pipelined OTTER core: arbitrates sequential fetch, branch redirects,
// mret returns and interrupts, and parks a redirect that arrives while instruction memory is busy.
module pc_sequencer #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input  logic        PS_CLK,
  input  logic        PS_RST,
  input  logic [31:0] PS_PC,
  input  logic        PS_STALL,
  input  logic        PS_IMEM_BUSY,
  input  logic        PS_BR_TAKEN,
  input  logic [31:0] PS_BR_TARGET,
  input  logic        PS_MRET,
  input  logic [31:0] PS_MEPC,
  input  logic        PS_INTR,
  input  logic        PS_INTR_EN,
  input  logic [31:0] PS_MTVEC,
  input  logic [31:0] PS_DEC_PC,
  input  logic        PS_DEC_VALID,
  output logic        PS_PC_LD,
  output logic [31:0] PS_PC_DIN,
  output logic        PS_FLUSH,
  output logic        PS_TRAP_TAKEN,
  output logic [31:0] PS_TRAP_EPC
);

  typedef enum logic [1:0] {StBoot, StRun, StPend} state_e;

  state_e      state_q, state_d;
  logic [31:0] pend_q, pend_d;
  logic        in_trap_q, in_trap_d;

  logic        intr_acc;
  logic        redirect;
  logic [31:0] target;

  // Event decode, only meaningful in StRun
  always_comb begin
    intr_acc = PS_INTR & PS_INTR_EN & ~in_trap_q & PS_DEC_VALID & ~PS_MRET;
    redirect = PS_MRET | intr_acc | PS_BR_TAKEN;
    if (PS_MRET) begin
      target = PS_MEPC;
    end else if (intr_acc) begin
      target = PS_MTVEC;
    end else begin
      target = PS_BR_TARGET;
    end
  end

  always_ff @(posedge PS_CLK) begin
    if (PS_RST) begin
      state_q   <= StBoot;
      pend_q    <= 32'h0;
      in_trap_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      in_trap_q <= in_trap_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    in_trap_d = in_trap_q;
    unique case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        if (PS_MRET) begin
          in_trap_d = 1'b0;
        end else if (intr_acc) begin
          in_trap_d = 1'b1;
        end
        if (redirect && PS_IMEM_BUSY) begin
          pend_d  = target;
          state_d = StPend;
        end
      end
      StPend: begin
        if (!PS_IMEM_BUSY) begin
          state_d = StRun;
        end
      end
      default: state_d = StBoot;
    endcase
  end

  always_comb begin
    PS_PC_LD      = 1'b0;
    PS_PC_DIN     = 32'h0;
    PS_FLUSH      = 1'b0;
    PS_TRAP_TAKEN = 1'b0;
    PS_TRAP_EPC   = 32'h0;
    if (PS_RST) begin
      PS_PC_DIN = RESET_VEC;
    end else begin
      unique case (state_q)
        StBoot: begin
          PS_PC_LD  = 1'b1;
          PS_PC_DIN = RESET_VEC;
          PS_FLUSH  = 1'b1;
        end
        StRun: begin
          if (redirect) begin
            PS_FLUSH  = 1'b1;
            PS_PC_LD  = ~PS_IMEM_BUSY;
            PS_PC_DIN = target;
            // Trap pulses on the event cycle even when the redirect itself is deferred
            if (intr_acc) begin
              PS_TRAP_TAKEN = 1'b1;
              PS_TRAP_EPC   = PS_BR_TAKEN ? PS_BR_TARGET : PS_DEC_PC;
            end
          end else begin
            PS_PC_LD  = ~PS_STALL & ~PS_IMEM_BUSY;
            PS_PC_DIN = PS_PC + 32'd4;
          end
        end
        StPend: begin
          PS_FLUSH  = 1'b1;
          PS_PC_LD  = ~PS_IMEM_BUSY;
          PS_PC_DIN = pend_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; a local PC register closes the loop on PS_PC_LD/PS_PC_DIN.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst, stall, busy, br, mret, intr, intr_en, dec_valid;
  logic [31:0] pc = 32'h0;
  logic [31:0] br_tgt, mepc, mtvec, dec_pc;
  logic        ld, flush, trap;
  logic [31:0] din, epc;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (ld) pc <= din;
  end

  pc_sequencer #(.RESET_VEC(32'h100)) dut (
    .PS_CLK(clk), .PS_RST(rst), .PS_PC(pc), .PS_STALL(stall), .PS_IMEM_BUSY(busy),
    .PS_BR_TAKEN(br), .PS_BR_TARGET(br_tgt), .PS_MRET(mret), .PS_MEPC(mepc),
    .PS_INTR(intr), .PS_INTR_EN(intr_en), .PS_MTVEC(mtvec), .PS_DEC_PC(dec_pc),
    .PS_DEC_VALID(dec_valid), .PS_PC_LD(ld), .PS_PC_DIN(din), .PS_FLUSH(flush),
    .PS_TRAP_TAKEN(trap), .PS_TRAP_EPC(epc)
  );

  // Inputs change 1 after the edge; outputs are sampled 2 later, well before the next edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 0; busy = 0; br = 0; mret = 0; intr = 0; intr_en = 1; dec_valid = 1;
    br_tgt = 0; mepc = 0; mtvec = 32'h1000; dec_pc = 0;
    step(); step(); settle();
    checks++; if (ld !== 1'b0) begin failures++; $display("FAIL rst_ld got=%0h exp=0", ld); end
    checks++; if (din !== 32'h100) begin failures++; $display("FAIL rst_din got=%0h exp=100", din); end
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL rst_flush got=%0h exp=0", flush); end
    checks++; if (trap !== 1'b0 || epc !== 32'h0) begin
      failures++; $display("FAIL rst_trap got=%0h/%0h exp=0/0", trap, epc); end
    step(); rst = 1'b0; settle();
    checks++; if (ld !== 1'b1 || din !== 32'h100 || flush !== 1'b1) begin
      failures++; $display("FAIL boot got=%0h/%0h/%0h exp=1/100/1", ld, din, flush); end
    step();
    checks++; if (pc !== 32'h100) begin failures++; $display("FAIL boot_pc got=%0h exp=100", pc); end
  endtask

  task automatic test_free_run();
    settle();
    checks++; if (ld !== 1'b1 || din !== 32'h104 || flush !== 1'b0) begin
      failures++; $display("FAIL seq1 got=%0h/%0h/%0h exp=1/104/0", ld, din, flush); end
    step(); settle();
    checks++; if (pc !== 32'h104 || din !== 32'h108) begin
      failures++; $display("FAIL seq2 got=%0h/%0h exp=104/108", pc, din); end
    step();
    checks++; if (pc !== 32'h108) begin failures++; $display("FAIL seq3 got=%0h exp=108", pc); end
  endtask

  task automatic test_stall();
    br = 1; br_tgt = 32'h200; step(); br = 0;
    checks++; if (pc !== 32'h200) begin failures++; $display("FAIL st_setup got=%0h exp=200", pc); end
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      settle();
      checks++; if (ld !== 1'b0 || flush !== 1'b0) begin
        failures++; $display("FAIL st_hold%0d got=%0h/%0h exp=0/0", i, ld, flush); end
      step();
    end
    checks++; if (pc !== 32'h200) begin failures++; $display("FAIL st_pc got=%0h exp=200", pc); end
    stall = 0; step();
    checks++; if (pc !== 32'h204) begin failures++; $display("FAIL st_rel got=%0h exp=204", pc); end
    stall = 1; br = 1; br_tgt = 32'h40; settle();
    checks++; if (ld !== 1'b1 || din !== 32'h40 || flush !== 1'b1) begin
      failures++; $display("FAIL st_br got=%0h/%0h/%0h exp=1/40/1", ld, din, flush); end
    step(); stall = 0; br = 0;
    checks++; if (pc !== 32'h40) begin failures++; $display("FAIL st_br_pc got=%0h exp=40", pc); end
  endtask

  task automatic test_branch_busy();
    busy = 1; br = 1; br_tgt = 32'h80;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) br_tgt = 32'h90;
      if (i == 2) br = 0;
      settle();
      checks++; if (ld !== 1'b0 || flush !== 1'b1) begin
        failures++; $display("FAIL bb_wait%0d got=%0h/%0h exp=0/1", i, ld, flush); end
      step();
    end
    busy = 0; settle();
    checks++; if (ld !== 1'b1 || din !== 32'h80 || flush !== 1'b1) begin
      failures++; $display("FAIL bb_go got=%0h/%0h/%0h exp=1/80/1", ld, din, flush); end
    step(); settle();
    checks++; if (pc !== 32'h80 || din !== 32'h84 || flush !== 1'b0) begin
      failures++; $display("FAIL bb_pc got=%0h/%0h/%0h exp=80/84/0", pc, din, flush); end
  endtask

  task automatic test_trap();
    intr = 1; dec_pc = 32'h300; settle();
    checks++; if (trap !== 1'b1 || epc !== 32'h300 || din !== 32'h1000 || ld !== 1'b1) begin
      failures++; $display("FAIL tr_take got=%0h/%0h/%0h/%0h exp=1/300/1000/1", trap, epc, din, ld); end
    step(); settle();
    checks++; if (pc !== 32'h1000 || trap !== 1'b0 || din !== 32'h1004) begin
      failures++; $display("FAIL tr_nest got=%0h/%0h/%0h exp=1000/0/1004", pc, trap, din); end
    step();
    mret = 1; mepc = 32'h300; settle();
    checks++; if (din !== 32'h300 || trap !== 1'b0 || flush !== 1'b1) begin
      failures++; $display("FAIL tr_mret got=%0h/%0h/%0h exp=300/0/1", din, trap, flush); end
    step(); mret = 0; dec_pc = 32'h320; settle();
    checks++; if (pc !== 32'h300 || trap !== 1'b1 || epc !== 32'h320) begin
      failures++; $display("FAIL tr_again got=%0h/%0h/%0h exp=300/1/320", pc, trap, epc); end
    step(); intr = 0; mret = 1; mepc = 32'h320; step(); mret = 0;
  endtask

  task automatic test_trap_branch();
    intr = 1; br = 1; br_tgt = 32'h500; dec_pc = 32'h400; settle();
    checks++; if (trap !== 1'b1 || epc !== 32'h500 || din !== 32'h1000) begin
      failures++; $display("FAIL tb_epc got=%0h/%0h/%0h exp=1/500/1000", trap, epc, din); end
    step(); intr = 0; br = 0;
    checks++; if (pc !== 32'h1000) begin failures++; $display("FAIL tb_pc got=%0h exp=1000", pc); end
    mret = 1; mepc = 32'h500; step(); mret = 0;
    checks++; if (pc !== 32'h500) begin failures++; $display("FAIL tb_ret got=%0h exp=500", pc); end
  endtask

  task automatic test_trap_pend();
    intr = 1; busy = 1; dec_pc = 32'h504; settle();
    checks++; if (trap !== 1'b1 || ld !== 1'b0 || flush !== 1'b1) begin
      failures++; $display("FAIL tp_take got=%0h/%0h/%0h exp=1/0/1", trap, ld, flush); end
    step(); busy = 0; settle();
    checks++; if (trap !== 1'b0 || ld !== 1'b1 || din !== 32'h1000) begin
      failures++; $display("FAIL tp_pend got=%0h/%0h/%0h exp=0/1/1000", trap, ld, din); end
    step(); settle();
    checks++; if (pc !== 32'h1000 || trap !== 1'b0) begin
      failures++; $display("FAIL tp_once got=%0h/%0h exp=1000/0", pc, trap); end
    intr = 0; mret = 1; mepc = 32'h504; step(); mret = 0;
  endtask

  task automatic test_wrap();
    br = 1; br_tgt = 32'hFFFF_FFFC; step(); br = 0; settle();
    checks++; if (ld !== 1'b1 || din !== 32'h0) begin
      failures++; $display("FAIL wrap got=%0h/%0h exp=1/0", ld, din); end
    step();
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL wrap_pc got=%0h exp=0", pc); end
  endtask

  task automatic test_reset_in_pend();
    busy = 1; br = 1; br_tgt = 32'h700; step(); br = 0;
    rst = 1; settle();
    checks++; if (ld !== 1'b0 || din !== 32'h100 || flush !== 1'b0) begin
      failures++; $display("FAIL rp_rst got=%0h/%0h/%0h exp=0/100/0", ld, din, flush); end
    step(); rst = 0; settle();
    checks++; if (ld !== 1'b1 || din !== 32'h100 || flush !== 1'b1) begin
      failures++; $display("FAIL rp_boot got=%0h/%0h/%0h exp=1/100/1", ld, din, flush); end
    step(); busy = 0; settle();
    checks++; if (pc !== 32'h100 || din !== 32'h104 || flush !== 1'b0) begin
      failures++; $display("FAIL rp_drop got=%0h/%0h/%0h exp=100/104/0", pc, din, flush); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_branch_busy();
    test_trap();
    test_trap_branch();
    test_trap_pend();
    test_wrap();
    test_reset_in_pend();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
